// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus a restoring divider for / and %.
// Define ALU_SEQ_RNG_EN to enable the op 8 xorshift random source (otherwise op 8 yields 0).
module alu_seq #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned IMM_W = 5
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [IMM_W-1:0] imm_i,
   output logic             ready_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             sign_o,
   output logic             dbz_o
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StExec, StDiv, StFin} state_e;

   state_e           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IMM_W-1:0] imm_q, imm_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             dz_q, dz_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d, sign_q, sign_d, dbz_q, dbz_d;

   logic [WIDTH-1:0] sx, zx, exec_res, res_val;
   logic [WIDTH:0]   rem_sh, diff;
   logic             res_load;

`ifdef ALU_SEQ_RNG_EN
   logic [WIDTH-1:0] rng_q, rng_d, rng_nxt;

   function automatic logic [WIDTH-1:0] rng_step(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] t;
      t = s + WIDTH'(1);
      t = t ^ (t << 7);
      t = t ^ (t >> 9);
      t = t ^ (t << 8);
      return t;
   endfunction

   assign rng_nxt = rng_step(rng_q);
`endif

   assign sx = WIDTH'($signed(imm_q));
   assign zx = WIDTH'(imm_q);

   always_comb begin
      exec_res = '0;
      case (op_q)
         4'd0:    exec_res = a_q + b_q + sx;
         4'd1:    exec_res = a_q - b_q - sx;
         4'd2:    exec_res = a_q & (b_q | zx);
         4'd3:    exec_res = a_q | b_q | zx;
         4'd4:    exec_res = a_q * (b_q + sx);
         4'd6:    exec_res = a_q ^ b_q;
`ifdef ALU_SEQ_RNG_EN
         4'd8:    exec_res = a_q;   // a_q holds the fresh RNG value when a was 0
`endif
         default: exec_res = '0;
      endcase
   end

   // One restoring step: shift the next dividend bit into the partial remainder.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, b_q};

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      imm_d    = imm_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      dz_d     = dz_q;
      done_d   = 1'b0;
      result_d = result_q;
      zero_d   = zero_q;
      sign_d   = sign_q;
      dbz_d    = dbz_q;
      res_load = 1'b0;
      res_val  = '0;
`ifdef ALU_SEQ_RNG_EN
      rng_d    = rng_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               op_d  = op_i;
               a_d   = a_i;
               b_d   = b_i;
               imm_d = imm_i;
               cnt_d = '0;
               dz_d  = 1'b0;
               if (op_i == 4'd5 || op_i == 4'd7) begin
                  state_d = StDiv;
`ifdef ALU_SEQ_RNG_EN
               end else if (op_i == 4'd8) begin
                  // Random value becomes the dividend, a becomes the divisor.
                  rng_d   = rng_nxt;
                  a_d     = rng_nxt;
                  b_d     = a_i;
                  state_d = (a_i != '0) ? StDiv : StExec;
`endif
               end else begin
                  state_d = StExec;
               end
            end
         end
         StExec: begin
            res_load = 1'b1;
            res_val  = exec_res;
            state_d  = StIdle;
         end
         StDiv: begin
            if (cnt_q == '0) begin
               cnt_d = CntW'(1);
               if (b_q == '0) begin
                  quo_d   = '1;
                  rem_d   = a_q;
                  dz_d    = 1'b1;
                  state_d = StFin;
               end else begin
                  quo_d = a_q;
                  rem_d = '0;
               end
            end else begin
               if (!diff[WIDTH]) begin
                  rem_d = diff[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = rem_sh[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH)) state_d = StFin;
            end
         end
         StFin: begin
            res_load = 1'b1;
            res_val  = (op_q == 4'd7) ? quo_q : rem_q;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (res_load) begin
         done_d   = 1'b1;
         result_d = res_val;
         zero_d   = (res_val == '0);
         sign_d   = res_val[WIDTH-1];
         dbz_d    = dz_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         dz_q     <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b1;
         sign_q   <= 1'b0;
         dbz_q    <= 1'b0;
`ifdef ALU_SEQ_RNG_EN
         rng_q    <= WIDTH'(1);
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         dz_q     <= dz_d;
         done_q   <= done_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         sign_q   <= sign_d;
         dbz_q    <= dbz_d;
`ifdef ALU_SEQ_RNG_EN
         rng_q    <= rng_d;
`endif
      end
   end

   assign ready_o  = (state_q == StIdle);
   assign done_o   = done_q;
   assign result_o = result_q;
   assign zero_o   = zero_q;
   assign sign_o   = sign_q;
   assign dbz_o    = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16, IMM_W=5.
// Op 8 expectations follow ALU_SEQ_RNG_EN when that macro is defined.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [3:0]  op;
   logic [15:0] a, b;
   logic [4:0]  imm;
   logic        ready, done, zero, sign, dbz;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(16), .IMM_W(5)) u_dut (
      .clk_i   (clk),
      .reset_i (reset),
      .start_i (start),
      .op_i    (op),
      .a_i     (a),
      .b_i     (b),
      .imm_i   (imm),
      .ready_o (ready),
      .done_o  (done),
      .result_o(result),
      .zero_o  (zero),
      .sign_o  (sign),
      .dbz_o   (dbz)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Launch one op and return cycles from the start edge to the done pulse (100 = timeout).
   task automatic run_op(input logic [3:0] o, input logic [15:0] va, input logic [15:0] vb,
                         input logic [4:0] vi, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      op = o; a = va; b = vb; imm = vi; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
      end
   endtask

`ifdef ALU_SEQ_RNG_EN
   function automatic logic [15:0] rng_ref(input logic [15:0] s);
      logic [15:0] t;
      t = s + 16'd1;
      t = t ^ (t << 7);
      t = t ^ (t >> 9);
      t = t ^ (t << 8);
      return t;
   endfunction
`endif

   initial begin
      int lat;
      int ndone;
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; imm = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      check("rst ready", ready, 1);
      check("rst done", done, 0);
      check("rst result", result, 0);
      check("rst zero", zero, 1);
      check("rst sign", sign, 0);
      check("rst dbz", dbz, 0);

      run_op(4'd0, 16'd5, 16'd3, 5'b11111, lat);
      check("add lat", lat, 1);
      check("add res", result, 16'd7);
      check("add zero", zero, 0);
      check("add sign", sign, 0);

      run_op(4'd7, 16'd100, 16'd7, 5'd0, lat);
      check("div lat", lat, 18);
      check("div res", result, 16'd14);
      check("div dbz", dbz, 0);
      run_op(4'd5, 16'd100, 16'd7, 5'd0, lat);
      check("mod lat", lat, 18);
      check("mod res", result, 16'd2);

      run_op(4'd7, 16'd1234, 16'd0, 5'd0, lat);
      check("div0 lat", lat, 2);
      check("div0 res", result, 16'hFFFF);
      check("div0 dbz", dbz, 1);
      run_op(4'd1, 16'd3, 16'd3, 5'd0, lat);
      check("sub res", result, 16'd0);
      check("sub zero", zero, 1);
      check("sub dbz", dbz, 0);
      run_op(4'd5, 16'd1234, 16'd0, 5'd0, lat);
      check("mod0 lat", lat, 2);
      check("mod0 res", result, 16'd1234);
      check("mod0 dbz", dbz, 1);

      run_op(4'd2, 16'hFFFF, 16'h0F00, 5'b00011, lat);
      check("and res", result, 16'h0F03);
      check("and dbz", dbz, 0);
      run_op(4'd3, 16'h1000, 16'h0200, 5'b11111, lat);
      check("or res", result, 16'h121F);
      run_op(4'd1, 16'd0, 16'd1, 5'd0, lat);
      check("neg res", result, 16'hFFFF);
      check("neg sign", sign, 1);
      run_op(4'd0, 16'hFFFF, 16'd1, 5'd0, lat);
      check("wrap res", result, 16'd0);
      check("wrap zero", zero, 1);
      run_op(4'd4, 16'd7, 16'd3, 5'b11110, lat);
      check("mul res", result, 16'd7);
      run_op(4'd9, 16'd5, 16'd5, 5'd1, lat);
      check("op9 lat", lat, 1);
      check("op9 res", result, 16'd0);
      run_op(4'd6, 16'h1234, 16'h1234, 5'd0, lat);
      run_op(4'd5, 16'd9, 16'd10, 5'd0, lat);
      check("mod small", result, 16'd9);
      run_op(4'd7, 16'hFFFF, 16'd1, 5'd0, lat);
      check("div big", result, 16'hFFFF);

`ifdef ALU_SEQ_RNG_EN
      begin
         logic [15:0] s1, s2, s3;
         s1 = rng_ref(16'd1);
         s2 = rng_ref(s1);
         s3 = rng_ref(s2);
         reset = 1'b1;
         @(posedge clk);
         @(negedge clk) reset = 1'b0;
         run_op(4'd8, 16'd0, 16'd0, 5'd0, lat);
         check("rng1 lat", lat, 1);
         check("rng1 res", result, s1);
         run_op(4'd6, 16'd1, 16'd2, 5'd0, lat);
         run_op(4'd8, 16'd0, 16'd0, 5'd0, lat);
         check("rng2 res", result, s2);
         run_op(4'd8, 16'd10, 16'd0, 5'd0, lat);
         check("rng3 lat", lat, 18);
         check("rng3 res", result, s3 % 16'd10);
         check("rng3 lt", result < 16'd10, 1);
      end
`else
      run_op(4'd8, 16'd0, 16'd0, 5'd0, lat);
      check("op8 lat", lat, 1);
      check("op8 res", result, 16'd0);
      check("op8 zero", zero, 1);
      run_op(4'd8, 16'd10, 16'd0, 5'd0, lat);
      check("op8b lat", lat, 1);
      check("op8b res", result, 16'd0);
`endif

      // Back-to-back: second start lands in the done cycle of the first.
      @(negedge clk);
      op = 4'd6; a = 16'h00FF; b = 16'h0F0F; imm = '0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1;
      check("b2b done1", done, 1);
      check("b2b res1", result, 16'h0FF0);
      check("b2b ready", ready, 1);
      op = 4'd4; a = 16'd3; b = 16'd4; imm = 5'd1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("b2b gap", done, 0);
      @(posedge clk);
      #1;
      check("b2b done2", done, 1);
      check("b2b res2", result, 16'd15);

      // Start pulsed while busy must be dropped.
      @(negedge clk);
      op = 4'd7; a = 16'd100; b = 16'd7; imm = '0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 3) begin
            op = 4'd0; a = 16'd1; b = 16'd1; start = 1'b1;
         end else if (lat == 4) begin
            start = 1'b0;
         end
         if (done) break;
      end
      check("busy lat", lat, 18);
      check("busy res", result, 16'd14);
      @(posedge clk);
      #1;
      check("busy nodone", done, 0);

      // Reset mid-divide aborts without a done pulse.
      @(negedge clk);
      op = 4'd7; a = 16'd100; b = 16'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      check("abort ready", ready, 1);
      check("abort res", result, 16'd0);
      check("abort zero", zero, 1);
      ndone = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      check("abort nodone", ndone, 0);

      // Reset wins over a simultaneous start.
      run_op(4'd0, 16'd5, 16'd3, 5'd0, lat);
      check("pre res", result, 16'd8);
      @(negedge clk);
      reset = 1'b1; start = 1'b1; op = 4'd0; a = 16'd5; b = 16'd3;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(posedge clk);
      #1;
      check("dom done", done, 0);
      check("dom ready", ready, 1);
      check("dom res", result, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
